prog_loader: RTL

// - Host-side writer into program memory: takes a framed byte stream and writes it into the ROM/RAM window.
// - The byte source is the UART RX byte port. The CPU later fetches these bytes from 0xF000 onward.
// - Holds the CPU in reset (cpu_hold) from power-up until a valid RUN frame arrives.
// - Replaces $readmemh preloading on hardware; the same frames drive instruction-set benches in simulation.

---
 rtl/prog_loader_if.sv | 17 +
 rtl/prog_loader.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// Byte stream in and memory write port out, seen from the host (master) and the loader (slave).
interface prog_loader_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   modport master (output in_data, in_valid,
                   input  in_ready, mem_we, mem_addr, mem_wdata);
   modport slave  (input  in_data, in_valid,
                   output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes WRITE-frame payloads into the program window
// and holds the CPU in reset until a RUN frame with a good checksum arrives.
module prog_loader #(
   parameter int                    ADDR_WIDTH     = 16,
   parameter int                    DATA_WIDTH     = 8,
   parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = 8'hA5,
   parameter logic [ADDR_WIDTH-1:0] WIN_BASE       = 16'hF000,
   parameter logic [ADDR_WIDTH:0]   WIN_SIZE       = 17'h01000,
   parameter int                    TIMEOUT_CYCLES = 1_000_000
)(
   input  logic           clk,
   input  logic           reset,
   prog_loader_if.slave   bus,
   output logic           cpu_hold,
   output logic           load_done,
   output logic           load_err
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]         LP_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_WIDTH:0]   LP_WIN_LO   = {1'b0, WIN_BASE};
   localparam logic [ADDR_WIDTH:0]   LP_WIN_HI   = LP_WIN_LO + WIN_SIZE - 1'b1;
   localparam logic [DATA_WIDTH-1:0] CMD_WRITE   = DATA_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] CMD_RUN     = DATA_WIDTH'(2);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_AHI, S_ALO, S_LEN, S_DATA, S_CSUM, S_ERR
   } state_t;

   state_t                r_state, w_nstate;
   logic [DATA_WIDTH-1:0] r_csum;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH:0]   r_cnt;
   logic [TW-1:0]         r_tmo;
   logic                  r_is_run;
   logic                  r_we, r_hold, r_done, r_err;
   logic [ADDR_WIDTH-1:0] r_maddr;
   logic [DATA_WIDTH-1:0] r_wdata;

   logic                  w_acc, w_busy, w_tmo, w_in_win, w_sync, w_csum_ok;
   logic                  w_we_nxt, w_done_nxt, w_hold_nxt, w_err_nxt;
   logic [DATA_WIDTH-1:0] w_sum;
   logic [ADDR_WIDTH:0]   w_addr_x;

   assign bus.in_ready = 1'b1;
   assign w_acc    = bus.in_valid & bus.in_ready;
   assign w_busy   = (r_state != S_IDLE) && (r_state != S_ERR);
   assign w_tmo    = (r_tmo == LP_TMO_LAST);
   assign w_sum    = r_csum + bus.in_data;
   assign w_addr_x = {1'b0, r_addr};
   assign w_in_win = (w_addr_x >= LP_WIN_LO) && (w_addr_x <= LP_WIN_HI);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_nstate;
   end

   always_comb begin
      w_nstate = r_state;
      if (w_busy && !w_acc && w_tmo) begin
         w_nstate = S_ERR;
      end else if (w_acc) begin
         unique case (r_state)
            S_IDLE, S_ERR: if (bus.in_data == SYNC_BYTE) w_nstate = S_CMD;
            S_CMD: begin
               if      (bus.in_data == CMD_WRITE) w_nstate = S_AHI;
               else if (bus.in_data == CMD_RUN)   w_nstate = S_CSUM;
               else                               w_nstate = S_ERR;
            end
            S_AHI:  w_nstate = S_ALO;
            S_ALO:  w_nstate = S_LEN;
            S_LEN:  w_nstate = S_DATA;
            S_DATA: begin
               if      (!w_in_win)                  w_nstate = S_ERR;
               else if (r_cnt == (DATA_WIDTH+1)'(1)) w_nstate = S_CSUM;
            end
            S_CSUM: w_nstate = (w_sum == '0) ? S_IDLE : S_ERR;
            default: w_nstate = S_ERR;
         endcase
      end
   end

   // Next values of the registered outputs; every output changes one edge after the byte.
   always_comb begin
      w_sync     = !w_busy && w_acc && (bus.in_data == SYNC_BYTE);
      w_csum_ok  = (r_state == S_CSUM) && w_acc && (w_sum == '0);
      w_we_nxt   = (r_state == S_DATA) && w_acc && w_in_win;
      w_done_nxt = w_csum_ok && !r_is_run;
      w_hold_nxt = r_hold;
      if (w_sync)                     w_hold_nxt = 1'b1;
      else if (w_csum_ok && r_is_run) w_hold_nxt = 1'b0;
      w_err_nxt = r_err;
      if (w_sync)                                        w_err_nxt = 1'b0;
      else if (w_nstate == S_ERR && r_state != S_ERR)    w_err_nxt = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_csum   <= '0;
         r_addr   <= '0;
         r_cnt    <= '0;
         r_tmo    <= '0;
         r_is_run <= 1'b0;
         r_we     <= 1'b0;
         r_maddr  <= '0;
         r_wdata  <= '0;
         r_hold   <= 1'b1;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_we   <= w_we_nxt;
         r_done <= w_done_nxt;
         r_hold <= w_hold_nxt;
         r_err  <= w_err_nxt;
         r_tmo  <= (!w_busy || w_acc) ? '0 : r_tmo + 1'b1;
         if (w_sync)               r_csum <= '0;
         else if (w_busy && w_acc) r_csum <= w_sum;
         if (w_we_nxt) begin
            r_maddr <= r_addr;
            r_wdata <= bus.in_data;
         end
         if (w_acc) begin
            unique case (r_state)
               S_CMD:  r_is_run <= (bus.in_data == CMD_RUN);
               S_AHI:  r_addr   <= {bus.in_data, r_addr[DATA_WIDTH-1:0]};
               S_ALO:  r_addr   <= {r_addr[ADDR_WIDTH-1:DATA_WIDTH], bus.in_data};
               // LEN of zero encodes a full 256-byte payload
               S_LEN:  r_cnt    <= (bus.in_data == '0) ? {1'b1, {DATA_WIDTH{1'b0}}}
                                                       : {1'b0, bus.in_data};
               S_DATA: begin
                  r_cnt  <= r_cnt - 1'b1;
                  r_addr <= r_addr + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.mem_we    = r_we;
   assign bus.mem_addr  = r_maddr;
   assign bus.mem_wdata = r_wdata;
   assign cpu_hold      = r_hold;
   assign load_done     = r_done;
   assign load_err      = r_err;
endmodule
